audio_mode_ctrl: RTL and testbench
==================================

AUDIO_MODE_CTRL -- requirements
Module: audio_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 4, number of SRAM track slots (2..8).
REQ-002 SHALL have parameter ADDR_W, default 23, SRAM word-address width.
REQ-003 SHALL have parameter TRACK_WORDS, default 2**20, words per track; NUM_TRACKS*TRACK_WORDS <= 2**ADDR_W.
REQ-004 SHALL have port i_clk, input, 1, system clock; reset i_rst, asynchronous, active-high; clock i_clk.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_key, input, 4, debounced keys, 1 = pressed; [0] record, [1] play, [2] pause/resume, [3] stop.
REQ-007 SHALL have port i_sw, input, 18, switches: [2:0] track, [15:8] mix mask, [7:4] pitch speed, [3] pitch mode, [16] pitch request, [17] mix request.
REQ-008 SHALL have port i_load_done, input, 1, initial SRAM load complete.
REQ-009 SHALL have port o_mode, output, 4, current state code.
REQ-010 SHALL have ports o_base and o_end, output, ADDR_W each, selected track region: first word and last word.
REQ-011 SHALL have ports o_rec_start, o_play_start, o_mix_start and o_pitch_start, output, 1 each, one-cycle start pulses.
REQ-012 SHALL have ports o_rec_pause and o_play_pause, output, 1 each, pause levels.
REQ-013 SHALL have port o_stop, output, 1, one-cycle stop pulse to the active engine.
REQ-014 SHALL have ports i_rec_done, i_play_done, i_mix_done and i_pitch_done, input, 1 each, engine completion pulses.
REQ-015 SHALL have ports o_mix_mask (NUM_TRACKS) and o_mix_num ($clog2(NUM_TRACKS+1)), outputs, mix track set and popcount.
REQ-016 SHALL have ports o_pitch_mode (1) and o_pitch_speed (4), outputs, latched pitch settings.

Function
REQ-017 SHALL register i_key and derive one-cycle rising-edge pulses; a held key SHALL produce exactly one pulse.
REQ-018 SHALL implement states LOAD=0, IDLE=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5, MIX=6, PITCH=7, and drive o_mode with the state code.
REQ-019 LOAD SHALL go to IDLE the cycle after i_load_done=1; all key events in LOAD SHALL be ignored.
REQ-020 In IDLE, the edge/level priority SHALL be: mix request, then pitch request, then record edge, then play edge.
REQ-021 On entry to REC/PLAY, track t = i_sw[2:0] mod NUM_TRACKS SHALL be latched; o_base = t*TRACK_WORDS and o_end = o_base+TRACK_WORDS-1, both registered on the transition edge.
REQ-022 The engine start pulse SHALL be high exactly in the first cycle of REC, PLAY, MIX or PITCH.
REQ-023 A pause edge SHALL toggle REC<->REC_PAUSE and PLAY<->PLAY_PAUSE; o_*_pause SHALL be 1 only in the matching *_PAUSE state.
REQ-024 A record edge while in PLAY*, or a play edge while in REC*, SHALL be ignored; the engine SHALL be stopped first.
REQ-025 A stop edge in any non-LOAD/IDLE state SHALL pulse o_stop for one cycle; the state SHALL hold until the matching done arrives.
REQ-026 The matching done SHALL return the FSM to IDLE next cycle and clear pause; done from a non-active engine SHALL be ignored.
REQ-027 Mix entry SHALL latch o_mix_mask = i_sw[8 +: NUM_TRACKS] and o_mix_num = popcount; a zero mask SHALL leave the FSM in IDLE with no start.
REQ-028 Pitch entry SHALL latch o_pitch_mode and o_pitch_speed; speed 0 SHALL be rejected and the FSM SHALL stay in IDLE.
REQ-029 Simultaneous stop and pause edges SHALL act as stop; done coinciding with stop SHALL still return to IDLE, with the o_stop pulse issued.

Reset
REQ-030 i_rst SHALL force LOAD, clear the edge registers, and zero all outputs, including mid-operation; no stop pulse SHALL be issued.

Configuration
REQ-031 With AUDIO_PITCH_EN defined, the PITCH state and pitch path SHALL exist; without it, i_sw[16] SHALL be ignored, o_pitch_start/o_pitch_mode/o_pitch_speed SHALL be tied 0, and the ports SHALL remain.

Structure
REQ-032 Package audio_ctrl_pkg SHALL hold the state enum, key-index constants and the switch field offsets.
REQ-033 Key edge detection SHALL live in sub-module key_edge (parameter width, registered edge pulses).

Verification
REQ-034 Reset, then i_load_done pulse -> o_mode 0 then 1; key presses before the pulse produce no starts.
REQ-035 NUM_TRACKS=4, i_sw[2:0]=2, KEY0 held 10 cycles -> one o_rec_start, o_base=0x200000, o_end=0x2FFFFF.
REQ-036 In PLAY: KEY2 -> o_play_pause=1; KEY2 again -> 0; KEY3 -> one o_stop; i_play_done -> IDLE next cycle.
REQ-037 i_sw[17]=1 with mask 0b1011 -> o_mix_start, o_mix_num=3; mask 0 -> remains IDLE, no start.
REQ-038 In REC, KEY2 and KEY3 in the same cycle -> o_stop only, no pause; a stray i_play_done is ignored.
REQ-039 i_rst asserted mid-REC -> o_mode=0 and all outputs 0 asynchronously; build without AUDIO_PITCH_EN plus i_sw[16]=1 -> no pitch start.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg
//   Shared definitions for the audio mode controller: FSM state encoding
//   (also the externally visible o_mode code), key bit positions and the
//   field offsets within the 18-bit switch bank.
package audio_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_LOAD       = 4'd0,
        ST_IDLE       = 4'd1,
        ST_REC        = 4'd2,
        ST_REC_PAUSE  = 4'd3,
        ST_PLAY       = 4'd4,
        ST_PLAY_PAUSE = 4'd5,
        ST_MIX        = 4'd6,
        ST_PITCH      = 4'd7
    } audio_state_e;

    // Key bit positions within i_key
    localparam int unsigned KEY_REC   = 0;
    localparam int unsigned KEY_PLAY  = 1;
    localparam int unsigned KEY_PAUSE = 2;
    localparam int unsigned KEY_STOP  = 3;
    localparam int unsigned KEY_W     = 4;

    // Switch field offsets within i_sw
    localparam int unsigned SW_TRACK_LSB  = 0;
    localparam int unsigned SW_TRACK_W    = 3;
    localparam int unsigned SW_PITCH_MODE = 3;
    localparam int unsigned SW_SPEED_LSB  = 4;
    localparam int unsigned SW_SPEED_W    = 4;
    localparam int unsigned SW_MASK_LSB   = 8;
    localparam int unsigned SW_PITCH_REQ  = 16;
    localparam int unsigned SW_MIX_REQ    = 17;
    localparam int unsigned SW_W          = 18;

endpackage

// File: rtl/audio_mode_ctrl_if.sv
// audio_mode_ctrl_if
//   Handshake bundle between the mode controller and the audio engines.
//   Signals (named from the controller's point of view):
//     o_rec_start / o_play_start / o_mix_start / o_pitch_start : one-cycle start pulses
//     o_rec_pause / o_play_pause : pause levels
//     o_stop                     : one-cycle stop pulse to the active engine
//     i_rec_done / i_play_done / i_mix_done / i_pitch_done : engine completion pulses
//   Modports: master = controller, slave = engine side.
interface audio_mode_ctrl_if;

    logic o_rec_start;
    logic o_play_start;
    logic o_mix_start;
    logic o_pitch_start;
    logic o_rec_pause;
    logic o_play_pause;
    logic o_stop;
    logic i_rec_done;
    logic i_play_done;
    logic i_mix_done;
    logic i_pitch_done;

    modport master (
        output o_rec_start, o_play_start, o_mix_start, o_pitch_start,
        output o_rec_pause, o_play_pause, o_stop,
        input  i_rec_done, i_play_done, i_mix_done, i_pitch_done
    );

    modport slave (
        input  o_rec_start, o_play_start, o_mix_start, o_pitch_start,
        input  o_rec_pause, o_play_pause, o_stop,
        output i_rec_done, i_play_done, i_mix_done, i_pitch_done
    );

endinterface

// File: rtl/key_edge.sv
// key_edge
//   Registers the debounced key bank and produces registered one-cycle
//   rising-edge pulses; a held key gives exactly one pulse.
//   Ports: i_clk, i_rst (async, active-high), i_key[WIDTH], o_edge[WIDTH].
module key_edge #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_key,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] key_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_q  <= '0;
            o_edge <= '0;
        end else begin
            key_q  <= i_key;
            o_edge <= i_key & ~key_q;
        end
    end

endmodule

// File: rtl/audio_mode_ctrl.sv
// audio_mode_ctrl
//   Top-level mode controller for the audio recorder: waits for the initial
//   SRAM load, then arbitrates record / play / mix / pitch operations from
//   keys and switches, selects the SRAM track region and drives the engine
//   handshake.
//   Ports:
//     i_clk, i_rst        : clock, asynchronous active-high reset
//     i_key[3:0]          : debounced keys (rec, play, pause, stop)
//     i_sw[17:0]          : track, pitch settings, mix mask, requests
//     i_load_done         : initial SRAM load complete
//     o_mode[3:0]         : current state code
//     o_base, o_end       : first / last word of selected track
//     o_mix_mask, o_mix_num : latched mix set and its popcount
//     o_pitch_mode, o_pitch_speed : latched pitch settings
//     eng                 : engine handshake (audio_mode_ctrl_if.master)
//   Build option: define AUDIO_PITCH_EN to include the PITCH state and pitch
//   path; otherwise the pitch request is ignored and pitch outputs read 0.
module audio_mode_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TRACKS  = 4,
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned TRACK_WORDS = 2**20
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [KEY_W-1:0]                  i_key,
    input  logic [SW_W-1:0]                   i_sw,
    input  logic                              i_load_done,
    output logic [3:0]                        o_mode,
    output logic [ADDR_W-1:0]                 o_base,
    output logic [ADDR_W-1:0]                 o_end,
    output logic [NUM_TRACKS-1:0]             o_mix_mask,
    output logic [$clog2(NUM_TRACKS+1)-1:0]   o_mix_num,
    output logic                              o_pitch_mode,
    output logic [SW_SPEED_W-1:0]             o_pitch_speed,
    audio_mode_ctrl_if.master                 eng
);

    localparam int unsigned MIX_NUM_W = $clog2(NUM_TRACKS + 1);
    localparam logic [ADDR_W-1:0] TW  = ADDR_W'(TRACK_WORDS);

    audio_state_e state_q, state_d;

    logic [KEY_W-1:0]      kev;
    logic [NUM_TRACKS-1:0] mask_sw;
    logic [MIX_NUM_W-1:0]  num_d;
    logic [3:0]            trk_wide;
    logic [ADDR_W-1:0]     base_d;
    logic                  active;

    logic                  first_q;
    logic                  stop_q;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     end_q;
    logic [NUM_TRACKS-1:0] mask_q;
    logic [MIX_NUM_W-1:0]  num_q;
`ifdef AUDIO_PITCH_EN
    logic                  pmode_q;
    logic [SW_SPEED_W-1:0] pspeed_q;
`endif

    // Only part of the switch bank is consumed in some configurations.
    logic unused_ok;
    assign unused_ok = ^{i_sw, eng.i_pitch_done};

    key_edge #(.WIDTH(KEY_W)) u_key_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_key  (i_key),
        .o_edge (kev)
    );

    // Track selection and mix popcount, computed from the live switches so
    // they can be captured on the IDLE exit edge.
    always_comb begin
        mask_sw  = i_sw[SW_MASK_LSB +: NUM_TRACKS];
        trk_wide = {1'b0, i_sw[SW_TRACK_LSB +: SW_TRACK_W]} % 4'(NUM_TRACKS);
        base_d   = ADDR_W'(trk_wide) * TW;
        num_d    = '0;
        for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
            num_d = num_d + MIX_NUM_W'(mask_sw[i]);
        end
        active = (state_q != ST_LOAD) && (state_q != ST_IDLE);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // Next-state logic. Done beats stop beats pause; a stop only pulses
    // o_stop and the state is held until the engine reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (i_load_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (i_sw[SW_MIX_REQ]) begin
                    if (mask_sw != '0) state_d = ST_MIX;
                end
`ifdef AUDIO_PITCH_EN
                else if (i_sw[SW_PITCH_REQ]) begin
                    if (i_sw[SW_SPEED_LSB +: SW_SPEED_W] != '0) state_d = ST_PITCH;
                end
`endif
                else if (kev[KEY_REC])  state_d = ST_REC;
                else if (kev[KEY_PLAY]) state_d = ST_PLAY;
            end
            ST_REC, ST_REC_PAUSE: begin
                if (eng.i_rec_done)
                    state_d = ST_IDLE;
                else if (!kev[KEY_STOP] && kev[KEY_PAUSE])
                    state_d = (state_q == ST_REC) ? ST_REC_PAUSE : ST_REC;
            end
            ST_PLAY, ST_PLAY_PAUSE: begin
                if (eng.i_play_done)
                    state_d = ST_IDLE;
                else if (!kev[KEY_STOP] && kev[KEY_PAUSE])
                    state_d = (state_q == ST_PLAY) ? ST_PLAY_PAUSE : ST_PLAY;
            end
            ST_MIX: if (eng.i_mix_done) state_d = ST_IDLE;
`ifdef AUDIO_PITCH_EN
            ST_PITCH: if (eng.i_pitch_done) state_d = ST_IDLE;
`else
            ST_PITCH: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered side state: entry marker, stop pulse and the settings
    // captured when leaving IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            first_q  <= 1'b0;
            stop_q   <= 1'b0;
            base_q   <= '0;
            end_q    <= '0;
            mask_q   <= '0;
            num_q    <= '0;
`ifdef AUDIO_PITCH_EN
            pmode_q  <= 1'b0;
            pspeed_q <= '0;
`endif
        end else begin
            first_q <= (state_q == ST_IDLE) && (state_d != ST_IDLE);
            stop_q  <= kev[KEY_STOP] && active;
            if (state_q == ST_IDLE) begin
                case (state_d)
                    ST_REC, ST_PLAY: begin
                        base_q <= base_d;
                        end_q  <= base_d + TW - ADDR_W'(1);
                    end
                    ST_MIX: begin
                        mask_q <= mask_sw;
                        num_q  <= num_d;
                    end
`ifdef AUDIO_PITCH_EN
                    ST_PITCH: begin
                        pmode_q  <= i_sw[SW_PITCH_MODE];
                        pspeed_q <= i_sw[SW_SPEED_LSB +: SW_SPEED_W];
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        o_mode            = state_q;
        o_base            = base_q;
        o_end             = end_q;
        o_mix_mask        = mask_q;
        o_mix_num         = num_q;
        eng.o_rec_start   = first_q && (state_q == ST_REC);
        eng.o_play_start  = first_q && (state_q == ST_PLAY);
        eng.o_mix_start   = first_q && (state_q == ST_MIX);
        eng.o_rec_pause   = (state_q == ST_REC_PAUSE);
        eng.o_play_pause  = (state_q == ST_PLAY_PAUSE);
        eng.o_stop        = stop_q;
`ifdef AUDIO_PITCH_EN
        eng.o_pitch_start = first_q && (state_q == ST_PITCH);
        o_pitch_mode      = pmode_q;
        o_pitch_speed     = pspeed_q;
`else
        eng.o_pitch_start = 1'b0;
        o_pitch_mode      = 1'b0;
        o_pitch_speed     = '0;
`endif
    end

endmodule

// File: tb/tb_audio_mode_ctrl.sv
// tb_audio_mode_ctrl
//   Directed scenarios followed by randomized stimulus, all checked every
//   cycle against a behavioural model of the controller's rules.
module tb_audio_mode_ctrl;

    localparam int NT = 4;
    localparam int AW = 23;
    localparam int TW = 1 << 20;
`ifdef AUDIO_PITCH_EN
    localparam bit PITCH_EN = 1'b1;
`else
    localparam bit PITCH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    key;
    logic [17:0]   sw;
    logic          load_done;
    logic [3:0]    mode;
    logic [AW-1:0] base_w, end_w;
    logic [NT-1:0] mix_mask;
    logic [2:0]    mix_num;
    logic          pitch_mode;
    logic [3:0]    pitch_speed;

    audio_mode_ctrl_if eng_if ();

    audio_mode_ctrl #(
        .NUM_TRACKS  (NT),
        .ADDR_W      (AW),
        .TRACK_WORDS (TW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key         (key),
        .i_sw          (sw),
        .i_load_done   (load_done),
        .o_mode        (mode),
        .o_base        (base_w),
        .o_end         (end_w),
        .o_mix_mask    (mix_mask),
        .o_mix_num     (mix_num),
        .o_pitch_mode  (pitch_mode),
        .o_pitch_speed (pitch_speed),
        .eng           (eng_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_rec_start, cnt_play_start, cnt_mix_start, cnt_pitch_start, cnt_stop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: mode number, pending key events, latched settings.
    int       m_mode;
    bit [3:0] m_kprev, m_kev;
    int       m_base, m_end, m_num;
    bit [3:0] m_mask, m_pspeed;
    bit       m_pmode, m_start, m_stop;

    task automatic model_reset();
        m_mode = 0; m_kprev = '0; m_kev = '0;
        m_base = 0; m_end = 0; m_num = 0; m_mask = '0;
        m_pspeed = '0; m_pmode = 1'b0; m_start = 1'b0; m_stop = 1'b0;
    endtask

    // One clock edge of the rules, using the inputs present at the edge.
    task automatic model_clock();
        int       nm;
        int       t;
        bit [3:0] ev;
        bit [3:0] msk;
        ev = m_kev;
        nm = m_mode;
        case (m_mode)
            0: if (load_done) nm = 1;
            1: begin
                if (sw[17]) begin
                    msk = sw[11:8];
                    if (msk != 0) begin
                        nm = 6; m_mask = msk; m_num = $countones(msk);
                    end
                end else if (PITCH_EN && sw[16]) begin
                    if (sw[7:4] != 0) begin
                        nm = 7; m_pmode = sw[3]; m_pspeed = sw[7:4];
                    end
                end else if (ev[0] || ev[1]) begin
                    nm = ev[0] ? 2 : 4;
                    t = int'(sw[2:0]) % NT;
                    m_base = t * TW;
                    m_end  = m_base + TW - 1;
                end
            end
            2, 3: if (eng_if.i_rec_done) nm = 1;
                  else if (ev[2] && !ev[3]) nm = 5 - m_mode;
            4, 5: if (eng_if.i_play_done) nm = 1;
                  else if (ev[2] && !ev[3]) nm = 9 - m_mode;
            6: if (eng_if.i_mix_done) nm = 1;
            7: if (eng_if.i_pitch_done) nm = 1;
            default: nm = 1;
        endcase
        m_stop  = ev[3] && (m_mode >= 2);
        m_start = (m_mode == 1) && (nm != 1);
        m_kev   = key & ~m_kprev;
        m_kprev = key;
        m_mode  = nm;
    endtask

    task automatic compare_all();
        logic [6:0] exp_p, got_p;
        exp_p = {m_start && m_mode == 2, m_start && m_mode == 4, m_start && m_mode == 6,
                 m_start && m_mode == 7, m_mode == 3, m_mode == 5, m_stop};
        got_p = {eng_if.o_rec_start, eng_if.o_play_start, eng_if.o_mix_start,
                 eng_if.o_pitch_start, eng_if.o_rec_pause, eng_if.o_play_pause, eng_if.o_stop};
        check("mode",   32'(mode), 32'(m_mode));
        check("pulses", 32'(got_p), 32'(exp_p));
        check("base",   32'(base_w), 32'(m_base));
        check("end",    32'(end_w), 32'(m_end));
        check("mix",    32'({mix_mask, mix_num}), 32'({m_mask, 3'(m_num)}));
        check("pitch",  32'({pitch_mode, pitch_speed}), 32'({m_pmode, m_pspeed}));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock();
        #1;
        compare_all();
        if (eng_if.o_rec_start)   cnt_rec_start++;
        if (eng_if.o_play_start)  cnt_play_start++;
        if (eng_if.o_mix_start)   cnt_mix_start++;
        if (eng_if.o_pitch_start) cnt_pitch_start++;
        if (eng_if.o_stop)        cnt_stop++;
    endtask

    task automatic press(input logic [3:0] k, input int n);
        key = k;
        repeat (n) tick();
        key = '0;
        tick();
    endtask

    task automatic done_pulse(input int which);
        case (which)
            0: eng_if.i_rec_done   = 1'b1;
            1: eng_if.i_play_done  = 1'b1;
            2: eng_if.i_mix_done   = 1'b1;
            default: eng_if.i_pitch_done = 1'b1;
        endcase
        tick();
        eng_if.i_rec_done = 1'b0; eng_if.i_play_done = 1'b0;
        eng_if.i_mix_done = 1'b0; eng_if.i_pitch_done = 1'b0;
    endtask

    task automatic reset_counts();
        cnt_rec_start = 0; cnt_play_start = 0; cnt_mix_start = 0;
        cnt_pitch_start = 0; cnt_stop = 0;
    endtask

    initial begin
        rst = 1'b1; key = '0; sw = '0; load_done = 1'b0;
        eng_if.i_rec_done = 1'b0; eng_if.i_play_done = 1'b0;
        eng_if.i_mix_done = 1'b0; eng_if.i_pitch_done = 1'b0;
        model_reset();
        reset_counts();
        #1;
        compare_all();
        tick(); tick();
        rst = 1'b0;

        // Keys during LOAD are ignored; load_done moves to IDLE next edge
        press(4'b0001, 4);
        press(4'b0010, 3);
        tick();
        check("load_hold_mode", 32'(mode), 32'd0);
        check("load_no_start", 32'(cnt_rec_start + cnt_play_start), 32'd0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("load_to_idle", 32'(mode), 32'd1);

        // Record track 2 with key held 10 cycles
        sw = 18'd2;
        reset_counts();
        press(4'b0001, 10);
        check("rec_one_start", 32'(cnt_rec_start), 32'd1);
        check("rec_mode", 32'(mode), 32'd2);
        check("rec_base", 32'(base_w), 32'h200000);
        check("rec_end", 32'(end_w), 32'h2FFFFF);
        press(4'b1000, 2);
        check("rec_stop_once", 32'(cnt_stop), 32'd1);
        check("rec_hold_after_stop", 32'(mode), 32'd2);
        done_pulse(0);
        check("rec_done_idle", 32'(mode), 32'd1);

        // Play with pause toggle, stop, done; record key ignored while playing
        sw = 18'd7;
        press(4'b0010, 2);
        check("play_mode", 32'(mode), 32'd4);
        press(4'b0001, 2);
        check("play_ignores_rec", 32'(mode), 32'd4);
        press(4'b0100, 2);
        check("play_pause_on", 32'(eng_if.o_play_pause), 32'd1);
        press(4'b0100, 2);
        check("play_pause_off", 32'(eng_if.o_play_pause), 32'd0);
        reset_counts();
        press(4'b1000, 3);
        check("play_stop_once", 32'(cnt_stop), 32'd1);
        done_pulse(1);
        check("play_done_idle", 32'(mode), 32'd1);

        // Mix with mask 1011, then zero mask
        sw = 18'h20000 | (18'b1011 << 8);
        reset_counts();
        tick();
        check("mix_start", 32'(eng_if.o_mix_start), 32'd1);
        check("mix_num", 32'(mix_num), 32'd3);
        sw = '0;
        tick();
        done_pulse(2);
        check("mix_done_idle", 32'(mode), 32'd1);
        sw = 18'h20000;
        repeat (4) tick();
        check("mix_zero_idle", 32'(mode), 32'd1);
        check("mix_zero_nostart", 32'(cnt_mix_start), 32'd1);
        sw = '0;

        // Record, then stop and pause in the same cycle, then stray play done
        press(4'b0001, 2);
        reset_counts();
        press(4'b1100, 2);
        check("stop_pause_no_pause", 32'(eng_if.o_rec_pause), 32'd0);
        check("stop_pause_stop", 32'(cnt_stop), 32'd1);
        done_pulse(1);
        check("stray_done_ignored", 32'(mode), 32'd2);
        done_pulse(0);
        check("rec_done_idle2", 32'(mode), 32'd1);

        // Asynchronous reset in the middle of a recording
        sw = 18'd1;
        press(4'b0001, 2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_base", 32'(base_w), 32'd0);
        check("arst_end", 32'(end_w), 32'd0);
        check("arst_pulses", 32'({eng_if.o_rec_start, eng_if.o_rec_pause, eng_if.o_stop}), 32'd0);
        tick();
        rst = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;

        // Pitch request: honoured only in a pitch-enabled build
        sw = 18'h10000 | (18'h5 << 4) | 18'h8;
        reset_counts();
        repeat (3) tick();
        check("pitch_starts", 32'(cnt_pitch_start), PITCH_EN ? 32'd1 : 32'd0);
        check("pitch_mode_state", 32'(mode), PITCH_EN ? 32'd7 : 32'd1);
        sw = '0;
        done_pulse(3);
        check("pitch_back_idle", 32'(mode), 32'd1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) key[b] = ~key[b];
            sw[15:0]  = 16'($urandom);
            sw[16]    = ($urandom_range(0, 7) == 0);
            sw[17]    = ($urandom_range(0, 15) == 0);
            load_done = ($urandom_range(0, 9) == 0);
            eng_if.i_rec_done   = ($urandom_range(0, 11) == 0);
            eng_if.i_play_done  = ($urandom_range(0, 11) == 0);
            eng_if.i_mix_done   = ($urandom_range(0, 11) == 0);
            eng_if.i_pitch_done = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
